// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared phase encoding and default 640x480@60 mode constants
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int DEF_WIDTH    = 11;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_H_POL    = 1'b0;
  localparam bit DEF_V_POL    = 1'b0;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - one raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int WIDTH  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] END_ACT  = WIDTH'(ACTIVE - 1);
  localparam logic [WIDTH-1:0] END_FP   = WIDTH'(ACTIVE + FP - 1);
  localparam logic [WIDTH-1:0] END_SYNC = WIDTH'(ACTIVE + FP + SYNC - 1);

  generate
    if (TOTAL > (2 ** WIDTH)) begin : g_bad_total
      $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, WIDTH);
    end
    if (ACTIVE < 1 || SYNC < 1) begin : g_bad_len
      $error("vga_axis_counter: ACTIVE and SYNC must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;

  // Phase moves on the step that lands the counter on the next boundary;
  // a zero-length porch is jumped over in that same step.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = PH_ACTIVE;
      end else begin
        count_d = count_q + WIDTH'(1);
        if (count_q == END_ACT) begin
          phase_d = (FP == 0) ? PH_SYNC : PH_FRONT;
        end else if (FP != 0 && count_q == END_FP) begin
          phase_d = PH_SYNC;
        end else if (BP != 0 && count_q == END_SYNC) begin
          phase_d = PH_BACK;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count  = count_q;
  assign wrap   = step && (count_q == LAST);
  assign sync   = (phase_q == PH_SYNC) ? POL : ~POL;
  assign active = (phase_q == PH_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator with registered outputs
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = DEF_H_POL,
  parameter bit V_POL    = DEF_V_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [WIDTH-1:0] out_hdata,
  output logic [WIDTH-1:0] out_vdata,
  output logic             out_blank,
  output logic             out_frame
);

  logic [WIDTH-1:0] h_count, v_count;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_active, v_active;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .WIDTH(WIDTH)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .step(en),
    .count(h_count), .wrap(h_wrap), .sync(h_sync), .active(h_active)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .WIDTH(WIDTH)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .step(en & h_wrap),
    .count(v_count), .wrap(v_wrap), .sync(v_sync), .active(v_active)
  );

  logic             hsync_q, vsync_q, blank_q, frame_q;
  logic             hsync_d, vsync_d, blank_d, frame_d;
  logic [WIDTH-1:0] hdata_q, vdata_q;

  always_comb begin
    hsync_d = h_sync;
    vsync_d = v_sync;
    blank_d = ~(h_active & v_active);
    frame_d = (h_count == '0) && (v_count == '0) && en;
  end

  // Outputs show the counters as they stood before this edge; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdata_q <= '0;
      vdata_q <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
    end else if (en) begin
      hdata_q <= h_count;
      vdata_q <= v_count;
      blank_q <= blank_d;
      frame_q <= frame_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign out_hsync = hsync_q;
  assign out_vsync = vsync_q;
  assign out_hdata = hdata_q;
  assign out_vdata = vdata_q;
  assign out_blank = blank_q;
  assign out_frame = frame_q;

endmodule
